// File: rtl/ysyx_220066_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_220066_ifu_pkg
//   Shared definitions for the RV64 instruction fetch unit:
//     RESET_PC_DEFAULT  first fetch address after reset
//     ifu_state_e       fetch FSM encodings (IDLE / REQ / WAIT)
//     ifu_entry_t       one instruction-buffer entry {pc, instr, err}
//     ENTRY_W           width of a buffer entry (64+32+1 = 97)
//     pc_misaligned     true when a target PC is not word aligned
// ---------------------------------------------------------------------------
package ysyx_220066_ifu_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } ifu_entry_t;

  localparam int ENTRY_W = $bits(ifu_entry_t);

  function automatic logic pc_misaligned(input logic [63:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_220066_ifu_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_220066_ifu_fifo
//   Small synchronous FIFO holding fetched instructions for the IFU.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     push, wdata     write one entry (caller guarantees space)
//     pop             remove the head entry (ignored when empty)
//     flush           drop all entries; overrides push and pop this cycle
//     head            entry at the head (don't-care when empty)
//     count           entries currently held
//     count_next      entries held after this cycle's push/pop/flush
//     empty           no entries held
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ysyx_220066_ifu_fifo
  import ysyx_220066_ifu_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = ENTRY_W,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign count      = count_reg;
  assign count_next = flush ? '0 : (count_reg + CW'(do_push) - CW'(do_pop));

  // Head is read straight from the storage array so ID sees a freshly
  // pushed entry in the cycle right after the push.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

endmodule

// File: rtl/ysyx_220066_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_220066_ifu
//   RV64 instruction fetch unit feeding the decode stage.
//   Keeps the PC, issues one word fetch at a time on a valid/ready port,
//   buffers returned instructions and presents {if_pc, instr, instr_err}.
//   Ports:
//     clk, rst                        clock, asynchronous active-high reset
//     req_valid/req_ready/req_addr    fetch request handshake
//     rsp_valid/rsp_data/rsp_err      single-cycle fetch response
//     redirect_valid/redirect_pc      PC change from EX (flushes the buffer)
//     halt                            stop issuing new fetches
//     instr_valid/id_ready            head handshake toward ID
//     instr/if_pc/instr_err           head entry (zero when empty)
//     fetch_fault                     sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module ysyx_220066_ifu
  import ysyx_220066_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        id_ready,
  output logic [31:0] instr,
  output logic [63:0] if_pc,
  output logic        instr_err,
  output logic        fetch_fault
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  ifu_state_e  state_reg;
  logic [63:0] next_pc_reg;
  logic [63:0] req_pc_reg;
  logic        discard_reg;
  logic        fetch_fault_reg;

  logic        handshake;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fault_next;
  logic        can_issue;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   fifo_count_next;
  logic [ENTRY_W-1:0] fifo_head;
  ifu_entry_t  push_entry;
  ifu_entry_t  head_entry;

  assign handshake = (state_reg == S_REQ) && req_ready;

  // A redirect kills both the response landing this cycle and any pop.
  assign fifo_push = (state_reg == S_WAIT) && rsp_valid && !discard_reg && !redirect_valid;
  assign fifo_pop  = !fifo_empty && id_ready && !redirect_valid;

  assign fault_next = redirect_valid ? pc_misaligned(redirect_pc) : fetch_fault_reg;

  // Issuing reserves a buffer slot, so the check uses the post-update count;
  // with at most one request outstanding the buffer can never overflow.
  assign can_issue = !halt && !fault_next && (fifo_count_next < CNT_W'(BUF_DEPTH));

  assign push_entry = '{pc: req_pc_reg, instr: rsp_data, err: rsp_err};
  assign head_entry = fifo_head;

  ysyx_220066_ifu_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .wdata      (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head       (fifo_head),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      next_pc_reg     <= RESET_PC;
      req_pc_reg      <= '0;
      discard_reg     <= 1'b0;
      fetch_fault_reg <= 1'b0;
    end else begin
      fetch_fault_reg <= fault_next;

      // A redirect wins over the post-handshake increment; the accepted
      // request then belongs to the old path and is discarded below.
      if (redirect_valid)  next_pc_reg <= redirect_pc;
      else if (handshake)  next_pc_reg <= next_pc_reg + 64'd4;

      if (handshake) req_pc_reg <= next_pc_reg;

      case (state_reg)
        S_IDLE: begin
          if (can_issue) state_reg <= S_REQ;
        end
        S_REQ: begin
          if (handshake) begin
            state_reg   <= S_WAIT;
            discard_reg <= redirect_valid;
          end else if (fault_next) begin
            // Withdraw the pending request: no fetch may go out while faulted.
            state_reg <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            // The response is consumed (buffered or dropped) either way, so a
            // coincident redirect must not leave discard armed for the next one.
            discard_reg <= 1'b0;
            state_reg   <= can_issue ? S_REQ : S_IDLE;
          end else if (redirect_valid) begin
            discard_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_valid   = (state_reg == S_REQ);
  assign req_addr    = next_pc_reg;
  assign fetch_fault = fetch_fault_reg;

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? 32'd0 : head_entry.instr;
  assign if_pc       = fifo_empty ? 64'd0 : head_entry.pc;
  assign instr_err   = fifo_empty ? 1'b0  : head_entry.err;

endmodule

// File: tb/tb_ysyx_220066_ifu.sv
module tb_ysyx_220066_ifu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [63:0] if_pc;
  logic        instr_err;
  logic        fetch_fault;

  ysyx_220066_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .id_ready       (id_ready),
    .instr          (instr),
    .if_pc          (if_pc),
    .instr_err      (instr_err),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req_valid;
    logic [63:0] req_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] if_pc;
    logic        instr_err;
    logic        fetch_fault;
  } outs_t;

  typedef struct packed {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        idr;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_0113;

  int n_cmp = 0;
  int n_bad = 0;

  // responder state: response arrives lat cycles after acceptance
  int          pend_cnt = 0;
  int          lat = 1;
  logic [63:0] pend_addr = '0;
  logic        force_en = 1'b0;
  logic [31:0] force_data = '0;

  vec_t vecs [8];

  function automatic logic [31:0] instr_for(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0013;
  endfunction

  function automatic outs_t cur_outs();
    outs_t o;
    o.req_valid   = req_valid;
    o.req_addr    = req_addr;
    o.instr_valid = instr_valid;
    o.instr       = instr;
    o.if_pc       = if_pc;
    o.instr_err   = instr_err;
    o.fetch_fault = fetch_fault;
    return o;
  endfunction

  function automatic outs_t mk(input logic rv, input logic [63:0] ra, input logic iv,
                               input logic [31:0] ins, input logic [63:0] pc,
                               input logic er, input logic ff);
    outs_t o;
    o = '{req_valid: rv, req_addr: ra, instr_valid: iv, instr: ins,
          if_pc: pc, instr_err: er, fetch_fault: ff};
    return o;
  endfunction

  task automatic chk_outs(input string name, input outs_t exp);
    outs_t act;
    act = cur_outs();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rv=%0b addr=%h iv=%0b instr=%h pc=%h err=%0b ff=%0b, want rv=%0b addr=%h iv=%0b instr=%h pc=%h err=%0b ff=%0b",
               name, act.req_valid, act.req_addr, act.instr_valid, act.instr, act.if_pc,
               act.instr_err, act.fetch_fault, exp.req_valid, exp.req_addr, exp.instr_valid,
               exp.instr, exp.if_pc, exp.instr_err, exp.fetch_fault);
    end else begin
      $display("ok   %s", name);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // One clock cycle with the automatic memory responder; called #1 after an edge.
  task automatic step(input logic id_rdy, input logic redir, input logic [63:0] rpc);
    logic        hs;
    logic [63:0] hs_addr;
    rsp_valid      = (pend_cnt == 1);
    rsp_data       = force_en ? force_data : instr_for(pend_addr);
    rsp_err        = 1'b0;
    id_ready       = id_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    hs      = req_valid && req_ready;
    hs_addr = req_addr;
    @(posedge clk);
    #1;
    if (pend_cnt > 0) pend_cnt--;
    if (hs) begin
      pend_cnt  = lat;
      pend_addr = hs_addr;
    end
    rsp_valid      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; id_ready = 1'b0;

    //                 rr    rv    data  err   id    rv    addr           iv    instr pc             err   ff
    vecs[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, mk(1'b1, 64'h8000_0000, 1'b0, 32'd0, 64'd0,         1'b0, 1'b0)};
    vecs[1] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, mk(1'b0, 64'h8000_0004, 1'b0, 32'd0, 64'd0,         1'b0, 1'b0)};
    vecs[2] = '{1'b1, 1'b1, I0,    1'b0, 1'b1, mk(1'b1, 64'h8000_0004, 1'b1, I0,    64'h8000_0000, 1'b0, 1'b0)};
    vecs[3] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, mk(1'b0, 64'h8000_0008, 1'b0, 32'd0, 64'd0,         1'b0, 1'b0)};
    vecs[4] = '{1'b1, 1'b1, I1,    1'b0, 1'b1, mk(1'b1, 64'h8000_0008, 1'b1, I1,    64'h8000_0004, 1'b0, 1'b0)};
    vecs[5] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, mk(1'b0, 64'h8000_000C, 1'b0, 32'd0, 64'd0,         1'b0, 1'b0)};
    vecs[6] = '{1'b1, 1'b1, I2,    1'b1, 1'b1, mk(1'b1, 64'h8000_000C, 1'b1, I2,    64'h8000_0008, 1'b1, 1'b0)};
    vecs[7] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, mk(1'b0, 64'h8000_0010, 1'b0, 32'd0, 64'd0,         1'b0, 1'b0)};

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset_state", mk(1'b0, 64'h8000_0000, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0));
    rst = 1'b0;

    // Streaming fetch with 1-cycle responses; row k is checked after edge k+1.
    for (int i = 0; i < 8; i++) begin
      req_ready = vecs[i].rr;
      rsp_valid = vecs[i].rv;
      rsp_data  = vecs[i].rd;
      rsp_err   = vecs[i].re;
      id_ready  = vecs[i].idr;
      @(posedge clk);
      #1;
      chk_outs($sformatf("stream_cycle%0d", i + 1), vecs[i].exp);
    end
    rsp_valid = 1'b0; rsp_err = 1'b0;
    pend_cnt = 1; pend_addr = 64'h8000_000C; lat = 1;

    // Back-pressure: ID stalls, buffer fills to two entries and fetch stops.
    repeat (10) step(1'b0, 1'b0, 64'd0);
    chk("stall_req_valid", {63'd0, req_valid}, 64'd0);
    chk("stall_head_pc", if_pc, 64'h8000_000C);
    chk("stall_head_instr", {32'd0, instr}, {32'd0, instr_for(64'h8000_000C)});
    step(1'b1, 1'b0, 64'd0);
    chk("drain1_pc", if_pc, 64'h8000_0010);
    chk("drain1_req_addr", req_addr, 64'h8000_0014);
    step(1'b1, 1'b0, 64'd0);
    chk("drain2_empty", {63'd0, instr_valid}, 64'd0);

    // Redirect while waiting: the in-flight response must be dropped.
    step(1'b1, 1'b0, 64'd0);
    lat = 2;
    step(1'b1, 1'b0, 64'd0);
    step(1'b1, 1'b1, 64'h8000_1000);
    force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, 64'd0);
    force_en = 1'b0; lat = 1;
    chk_outs("redir_wait_drop", mk(1'b1, 64'h8000_1000, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 64'd0);
    chk_outs("redir_wait_new_head",
             mk(1'b1, 64'h8000_1004, 1'b1, instr_for(64'h8000_1000), 64'h8000_1000, 1'b0, 1'b0));

    // Redirect coincident with a response and a head pop.
    step(1'b0, 1'b0, 64'd0);
    step(1'b1, 1'b1, 64'h8000_2000);
    chk_outs("redir_rsp_pop", mk(1'b1, 64'h8000_2000, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 64'd0);
    chk("redir_rsp_next_pc", if_pc, 64'h8000_2000);

    // Misaligned redirect raises a sticky fault; an aligned one clears it.
    req_ready = 1'b0;
    step(1'b1, 1'b1, 64'h8000_0002);
    req_ready = 1'b1;
    chk_outs("fault_set", mk(1'b0, 64'h8000_0002, 1'b0, 32'd0, 64'd0, 1'b0, 1'b1));
    repeat (4) step(1'b1, 1'b0, 64'd0);
    chk_outs("fault_hold", mk(1'b0, 64'h8000_0002, 1'b0, 32'd0, 64'd0, 1'b0, 1'b1));
    step(1'b1, 1'b1, 64'h8000_0100);
    chk_outs("fault_clear", mk(1'b1, 64'h8000_0100, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 64'd0);
    chk("fault_resume_pc", if_pc, 64'h8000_0100);

    // Asynchronous reset pulse while a fetch is outstanding.
    step(1'b1, 1'b0, 64'd0);
    rst = 1'b1;
    #2;
    chk_outs("async_reset_mid_wait", mk(1'b0, 64'h8000_0000, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0));
    step(1'b1, 1'b0, 64'd0);
    pend_cnt = 0;
    chk_outs("reset_held_rsp", mk(1'b0, 64'h8000_0000, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0));
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0BAD; id_ready = 1'b0;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    chk_outs("rsp_in_idle_ignored", mk(1'b1, 64'h8000_0000, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0));

    // PC wraps from the top of the address space to zero.
    req_ready = 1'b0;
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    req_ready = 1'b1;
    chk("wrap_req_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 64'd0);
    chk("wrap_next_pc", req_addr, 64'd0);
    step(1'b0, 1'b0, 64'd0);
    chk("wrap_head_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // halt: the outstanding fetch completes and is buffered, then nothing more.
    step(1'b1, 1'b0, 64'd0);
    halt = 1'b1;
    step(1'b0, 1'b0, 64'd0);
    chk_outs("halt_buffered", mk(1'b0, 64'd4, 1'b1, instr_for(64'd0), 64'd0, 1'b0, 1'b0));
    repeat (3) step(1'b0, 1'b0, 64'd0);
    chk("halt_no_req", {63'd0, req_valid}, 64'd0);
    halt = 1'b0;
    step(1'b0, 1'b0, 64'd0);
    chk_outs("halt_release", mk(1'b1, 64'd4, 1'b1, instr_for(64'd0), 64'd0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
